// File: rtl/cache_axi_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cache_axi_arbiter: shares one AXI3 master between i_cache and d_cache   |
// | Rev 1.0 - round-robin read arbitration, write pass-through              |
// +------------------------------------------------------------------------+
module cache_axi_arbiter #(
  parameter int ID_W      = 4,
  parameter int ICACHE_ID = 0,
  parameter int DCACHE_ID = 1
) (
  input  logic            clk,
  input  logic            rst,
  // i_cache read
  input  logic [31:0]     i_araddr,
  input  logic [3:0]      i_arlen,
  input  logic [2:0]      i_arsize,
  input  logic            i_arvalid,
  output logic            i_arready,
  output logic [31:0]     i_rdata,
  output logic            i_rlast,
  output logic            i_rvalid,
  input  logic            i_rready,
  // d_cache read
  input  logic [31:0]     d_araddr,
  input  logic [3:0]      d_arlen,
  input  logic [2:0]      d_arsize,
  input  logic            d_arvalid,
  output logic            d_arready,
  output logic [31:0]     d_rdata,
  output logic            d_rlast,
  output logic            d_rvalid,
  input  logic            d_rready,
  // d_cache write
  input  logic [31:0]     d_awaddr,
  input  logic [3:0]      d_awlen,
  input  logic [2:0]      d_awsize,
  input  logic            d_awvalid,
  output logic            d_awready,
  input  logic [31:0]     d_wdata,
  input  logic [3:0]      d_wstrb,
  input  logic            d_wlast,
  input  logic            d_wvalid,
  output logic            d_wready,
  output logic            d_bvalid,
  input  logic            d_bready,
  // AXI3 master
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [3:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [3:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rstate_t;

  rstate_t state_q, state_d;
  logic    grant_q, grant_d;           // 0 = i_cache, 1 = d_cache
  logic    last_grant_q, last_grant_d;

  // Responses are routed by the grant register alone.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, bid, bresp};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= R_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    arvalid      = 1'b0;
    i_arready    = 1'b0;
    d_arready    = 1'b0;
    rready       = 1'b0;
    i_rvalid     = 1'b0;
    d_rvalid     = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (i_arvalid || d_arvalid) begin
          state_d = R_ADDR;
          // On a tie the master that did not win last time goes first.
          grant_d = (i_arvalid && d_arvalid) ? ~last_grant_q : d_arvalid;
        end
      end
      R_ADDR: begin
        arvalid   = grant_q ? d_arvalid : i_arvalid;
        i_arready = ~grant_q & arready;
        d_arready = grant_q & arready;
        if (arvalid && arready) state_d = R_DATA;
      end
      R_DATA: begin
        rready   = grant_q ? d_rready : i_rready;
        i_rvalid = ~grant_q & rvalid;
        d_rvalid = grant_q & rvalid;
        if (rvalid && rready && rlast) begin
          state_d      = R_IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign arid    = grant_q ? ID_W'(DCACHE_ID) : ID_W'(ICACHE_ID);
  assign araddr  = grant_q ? d_araddr : i_araddr;
  assign arlen   = grant_q ? d_arlen  : i_arlen;
  assign arsize  = grant_q ? d_arsize : i_arsize;
  assign arburst = 2'b01;

  assign i_rdata = rdata;
  assign d_rdata = rdata;
  assign i_rlast = rlast;
  assign d_rlast = rlast;

  // Write channels belong to d_cache only and never touch the read FSM.
  assign awid      = ID_W'(DCACHE_ID);
  assign awaddr    = d_awaddr;
  assign awlen     = d_awlen;
  assign awsize    = d_awsize;
  assign awburst   = 2'b01;
  assign awvalid   = d_awvalid;
  assign d_awready = awready;
  assign wid       = ID_W'(DCACHE_ID);
  assign wdata     = d_wdata;
  assign wstrb     = d_wstrb;
  assign wlast     = d_wlast;
  assign wvalid    = d_wvalid;
  assign d_wready  = wready;
  assign d_bvalid  = bvalid;
  assign bready    = d_bready;

endmodule
`default_nettype wire
